// File: rtl/alu_datapath.sv
// 8-bit ALU datapath: add/sub, Booth radix-2 multiply, non-restoring divide.
// Executes one micro-operation per cycle from the control word c.
module alu_datapath (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  x,
  input  logic [7:0]  y,
  input  logic [14:0] c,
  output logic        q_0,
  output logic        q_min1,
  output logic        sign,
  output logic        cnt7,
  output logic [15:0] result,
  output logic        ovf,
  output logic        dbz
);

  typedef enum logic [1:0] {
    MODE_ADD = 2'd0,
    MODE_MUL = 2'd1,
    MODE_DIV = 2'd2
  } mode_e;

  logic [9:0]  a_q, a_d;
  logic [7:0]  q_q, q_d;
  logic        qm1_q, qm1_d;
  logic [7:0]  m_q, m_d;
  logic [2:0]  cnt_q, cnt_d;
  mode_e       mode_q, mode_d;
  logic [15:0] result_q, result_d;
  logic        ovf_q, ovf_d;
  logic        dbz_q, dbz_d;

  logic [9:0]  m_ext;
  logic [9:0]  addsub;
  logic [7:0]  sum8;
  logic        ovf8;
  logic [17:0] shl;

  always_comb begin
    // Divisor is unsigned, so M is zero-extended only while dividing.
    m_ext  = (mode_q == MODE_DIV) ? {2'b00, m_q} : {{2{m_q[7]}}, m_q};
    addsub = c[5] ? (a_q - m_ext) : (a_q + m_ext);
    sum8   = c[5] ? (a_q[7:0] - m_q) : (a_q[7:0] + m_q);
    ovf8   = c[5] ? ((a_q[7] ^ m_q[7]) & (sum8[7] ^ a_q[7]))
                  : (~(a_q[7] ^ m_q[7]) & (sum8[7] ^ a_q[7]));
    shl    = {a_q[8:0], q_q, 1'b0};
  end

  always_comb begin
    a_d      = a_q;
    q_d      = q_q;
    qm1_d    = qm1_q;
    m_d      = m_q;
    cnt_d    = cnt_q;
    mode_d   = mode_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    dbz_d    = dbz_q;
    if (c[0]) begin
      a_d      = {{2{x[7]}}, x};
      m_d      = y;
      q_d      = '0;
      qm1_d    = 1'b0;
      cnt_d    = '0;
      mode_d   = MODE_ADD;
      result_d = '0;
      ovf_d    = 1'b0;
      dbz_d    = 1'b0;
    end else if (c[1]) begin
      a_d      = '0;
      q_d      = x;
      qm1_d    = 1'b0;
      m_d      = y;
      cnt_d    = '0;
      mode_d   = MODE_MUL;
      result_d = '0;
      ovf_d    = 1'b0;
      dbz_d    = 1'b0;
    end else if (c[2]) begin
      a_d      = '0;
      q_d      = x;
      m_d      = y;
      cnt_d    = 3'd7;
      mode_d   = MODE_DIV;
      result_d = '0;
      dbz_d    = (y == 8'd0);
    end else if (c[3]) begin
      if (mode_q == MODE_DIV) {a_d, q_d} = shl;
    end else if (c[4]) begin
      a_d = addsub;
      if (mode_q == MODE_ADD) ovf_d = ovf8;
    end else if (c[6]) begin
      q_d[0] = ~a_q[9];
    end else if (c[7] || c[10]) begin
      cnt_d = cnt_q + 3'd1;
    end else if (c[8]) begin
      a_d   = {a_q[9], a_q[9:1]};
      q_d   = {a_q[0], q_q[7:1]};
      qm1_d = q_q[0];
    end else if (c[9]) begin
      // Last divide iteration keeps its quotient bit in place.
      if (cnt_q != 3'd7) {a_d, q_d} = shl;
    end else if (c[11]) begin
      a_d = a_q + m_ext;
    end else if (c[12]) begin
      result_d[7:0] = a_q[7:0];
    end else if (c[13]) begin
      result_d = {a_q[7:0], q_q};
    end else if (c[14]) begin
      result_d[15:8] = q_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      q_q      <= '0;
      qm1_q    <= 1'b0;
      m_q      <= '0;
      cnt_q    <= '0;
      mode_q   <= MODE_ADD;
      result_q <= '0;
      ovf_q    <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      q_q      <= q_d;
      qm1_q    <= qm1_d;
      m_q      <= m_d;
      cnt_q    <= cnt_d;
      mode_q   <= mode_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      dbz_q    <= dbz_d;
    end
  end

  assign q_0    = q_q[0];
  assign q_min1 = qm1_q;
  assign sign   = a_q[9];
  assign cnt7   = (cnt_q == 3'd7);
  assign result = result_q;
  assign ovf    = ovf_q;
  assign dbz    = dbz_q;

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: the bench plays the control unit and
// checks results against hand-computed values.
module tb_alu_datapath;

  logic        clk;
  logic        rst;
  logic [7:0]  x;
  logic [7:0]  y;
  logic [14:0] c;
  logic        q_0;
  logic        q_min1;
  logic        sign;
  logic        cnt7;
  logic [15:0] result;
  logic        ovf;
  logic        dbz;

  int checks;
  int errors;

  localparam logic [14:0] C0  = 15'h0001;
  localparam logic [14:0] C1  = 15'h0002;
  localparam logic [14:0] C2  = 15'h0004;
  localparam logic [14:0] C3  = 15'h0008;
  localparam logic [14:0] C4  = 15'h0010;
  localparam logic [14:0] C5  = 15'h0020;
  localparam logic [14:0] C6  = 15'h0040;
  localparam logic [14:0] C7  = 15'h0080;
  localparam logic [14:0] C8  = 15'h0100;
  localparam logic [14:0] C9  = 15'h0200;
  localparam logic [14:0] C10 = 15'h0400;
  localparam logic [14:0] C11 = 15'h0800;
  localparam logic [14:0] C12 = 15'h1000;
  localparam logic [14:0] C13 = 15'h2000;
  localparam logic [14:0] C14 = 15'h4000;

  alu_datapath dut (
    .clk    (clk),
    .rst    (rst),
    .x      (x),
    .y      (y),
    .c      (c),
    .q_0    (q_0),
    .q_min1 (q_min1),
    .sign   (sign),
    .cnt7   (cnt7),
    .result (result),
    .ovf    (ovf),
    .dbz    (dbz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One micro-op per cycle; outputs settle #1 after the edge.
  task automatic cyc(input logic [14:0] w);
    c = w;
    @(posedge clk);
    #1;
    c = '0;
  endtask

  task automatic run_add(input logic [7:0] xa, input logic [7:0] ya, input logic sub);
    x = xa;
    y = ya;
    cyc(C0);
    cyc(C3);
    cyc(sub ? (C4 | C5) : C4);
    cyc(C12);
  endtask

  task automatic booth_iter(output logic last);
    if ({q_0, q_min1} == 2'b01)      cyc(C4);
    else if ({q_0, q_min1} == 2'b10) cyc(C4 | C5);
    cyc(C8);
    last = cnt7;
    cyc(C10);
  endtask

  task automatic run_mul(input logic [7:0] xa, input logic [7:0] ya, output logic done);
    logic last;
    x = xa;
    y = ya;
    cyc(C1);
    done = 1'b0;
    for (int i = 0; i < 9 && !done; i++) begin
      booth_iter(last);
      if (last) done = 1'b1;
    end
    cyc(C13);
  endtask

  task automatic run_div(input logic [7:0] xa, input logic [7:0] ya, output logic done,
                         output logic q0_hold, output logic sign_hold, output logic cnt7_hold);
    logic last;
    x = xa;
    y = ya;
    cyc(C2);
    cyc(C3);
    done = 1'b0;
    q0_hold = 1'b0;
    sign_hold = 1'b0;
    cnt7_hold = 1'b0;
    for (int i = 0; i < 9 && !done; i++) begin
      cyc(sign ? C4 : (C4 | C5));
      cyc(C6);
      cyc(C7);
      last = cnt7;
      cyc(C9);
      if (last) begin
        done = 1'b1;
        q0_hold = q_0;
        sign_hold = sign;
        cnt7_hold = cnt7;
      end
    end
    if (sign) cyc(C11);
    cyc(C12);
    cyc(C14);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #1;
    checks++;
    if ({q_0, q_min1, sign, cnt7, result, ovf, dbz} !== 22'd0) begin
      errors++;
      $display("FAIL reset: got q0=%b qm1=%b sign=%b cnt7=%b result=%h ovf=%b dbz=%b, want all 0",
               q_0, q_min1, sign, cnt7, result, ovf, dbz);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add;
    run_add(8'd100, 8'd50, 1'b0);
    checks++;
    if (result !== 16'h0096) begin
      errors++;
      $display("FAIL add_result: got %h want 0096", result);
    end
    checks++;
    if (ovf !== 1'b1) begin
      errors++;
      $display("FAIL add_ovf: got %b want 1", ovf);
    end
    run_add(8'd5, 8'd7, 1'b1);
    checks++;
    if (result !== 16'h00FE) begin
      errors++;
      $display("FAIL sub_result: got %h want 00fe", result);
    end
    checks++;
    if (ovf !== 1'b0) begin
      errors++;
      $display("FAIL sub_ovf: got %b want 0", ovf);
    end
    run_add(8'h80, 8'h01, 1'b1);
    checks++;
    if (result !== 16'h007F || ovf !== 1'b1) begin
      errors++;
      $display("FAIL sub_ovf_neg: got result=%h ovf=%b want 007f/1", result, ovf);
    end
  endtask

  task automatic test_mul;
    logic done;
    run_mul(8'hFD, 8'd7, done);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL mul_timeout: got done=%b want 1", done);
    end
    checks++;
    if (result !== 16'hFFEB) begin
      errors++;
      $display("FAIL mul_neg3x7: got %h want ffeb", result);
    end
    checks++;
    if (cnt7 !== 1'b0) begin
      errors++;
      $display("FAIL mul_cnt_wrap: got cnt7=%b want 0", cnt7);
    end
    run_mul(8'h80, 8'h80, done);
    checks++;
    if (result !== 16'h4000 || done !== 1'b1) begin
      errors++;
      $display("FAIL mul_min_min: got %h done=%b want 4000/1", result, done);
    end
    run_mul(8'h7F, 8'h80, done);
    checks++;
    if (result !== 16'hC080 || done !== 1'b1) begin
      errors++;
      $display("FAIL mul_max_min: got %h done=%b want c080/1", result, done);
    end
  endtask

  task automatic test_div;
    logic done, q0h, sh, c7h;
    run_div(8'd100, 8'd7, done, q0h, sh, c7h);
    checks++;
    if (result !== 16'h0E02 || done !== 1'b1) begin
      errors++;
      $display("FAIL div_100_7: got %h done=%b want 0e02/1", result, done);
    end
    checks++;
    if (dbz !== 1'b0) begin
      errors++;
      $display("FAIL div_dbz_clear: got %b want 0", dbz);
    end
    run_div(8'd255, 8'd16, done, q0h, sh, c7h);
    checks++;
    if (result !== 16'h0F0F || done !== 1'b1) begin
      errors++;
      $display("FAIL div_255_16: got %h done=%b want 0f0f/1", result, done);
    end
  endtask

  task automatic test_div_by_zero;
    logic done, q0h, sh, c7h;
    run_div(8'h5A, 8'h00, done, q0h, sh, c7h);
    checks++;
    if (dbz !== 1'b1) begin
      errors++;
      $display("FAIL dbz_flag: got %b want 1", dbz);
    end
    checks++;
    if (result !== 16'hFF5A || done !== 1'b1) begin
      errors++;
      $display("FAIL dbz_result: got %h done=%b want ff5a/1", result, done);
    end
    checks++;
    if ({q0h, sh, c7h} !== 3'b101) begin
      errors++;
      $display("FAIL c9_hold: got q0=%b sign=%b cnt7=%b want 1/0/1", q0h, sh, c7h);
    end
  endtask

  task automatic test_reset_mid_mul;
    logic last;
    x = 8'hFD;
    y = 8'd7;
    cyc(C1);
    for (int i = 0; i < 3; i++) booth_iter(last);
    if ({q_0, q_min1} == 2'b01)      c = C4;
    else if ({q_0, q_min1} == 2'b10) c = C4 | C5;
    else                             c = C8;
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({q_0, q_min1, sign, cnt7, result, ovf, dbz} !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid_mul: got q0=%b qm1=%b sign=%b cnt7=%b result=%h ovf=%b dbz=%b, want all 0",
               q_0, q_min1, sign, cnt7, result, ovf, dbz);
    end
    c = '0;
    @(negedge clk);
    rst = 1'b0;
    run_add(8'd1, 8'd1, 1'b0);
    checks++;
    if (result !== 16'h0002 || ovf !== 1'b0) begin
      errors++;
      $display("FAIL add_after_reset: got result=%h ovf=%b want 0002/0", result, ovf);
    end
  endtask

  task automatic test_back_to_back;
    logic done;
    run_mul(8'd3, 8'hFE, done);
    checks++;
    if (result !== 16'hFFFA || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_mul: got %h done=%b want fffa/1", result, done);
    end
    run_add(8'd127, 8'd1, 1'b0);
    checks++;
    if (result !== 16'h0080 || ovf !== 1'b1) begin
      errors++;
      $display("FAIL b2b_add: got result=%h ovf=%b want 0080/1", result, ovf);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    x = '0;
    y = '0;
    c = '0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_div_by_zero();
    test_reset_mid_mul();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
